// File: rtl/ifetch_pkg.sv
// Shared fetch/decode definitions.
// Used by ifetch and the control decoder.
package ifetch_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;

  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_e;

  function automatic logic is_halt(
    input logic [2:0] opc
  );
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port.
// master = fetch side, slave = memory side.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = INSTR_W
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );

endinterface

// File: rtl/ifetch_skid.sv
// One-entry {instr, pc} buffer catching
// the response that lands during a stall.
module fetch_skid #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [DW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: fetch PC, imem
// request, skid on stall, IF/ID register.
module ifetch #(
  parameter int ADDR_W   = 9,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  ifetch_if.master           imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               halted
);

  import ifetch_pkg::*;

  fetch_state_e       state_q;
  logic               halted_q;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;

  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;

  logic               skid_v;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic               run, resp, issue;
  logic               skid_load, skid_drain;
  logic               skid_flush;
  logic               ld_valid, halt_load;
  logic [INSTR_W-1:0] ld_instr;
  logic [ADDR_W-1:0]  ld_pc;

  always_comb begin
    run   = (state_q == RUN);
    resp  = inflight_q && imem.imem_rvalid;
    issue = !reset && run && !redirect &&
            !skid_v && !(stall && inflight_q);

    skid_load  = resp && (stall || skid_v);
    skid_drain = !stall && skid_v;

    ld_valid = skid_v || resp;
    ld_instr = imem.imem_rdata;
    ld_pc    = fetch_pc_q;
    unique case (1'b1)
      skid_v: begin
        ld_instr = skid_instr;
        ld_pc    = skid_pc;
      end
      default: ;
    endcase

    halt_load = !redirect && !stall && ld_valid &&
                is_halt(ld_instr[OPC_MSB:OPC_LSB]);
    skid_flush = redirect || halt_load;
  end

  // fetch_pc already points one past an in-flight
  // request, which is exactly the IF/ID pc value
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = issue && !halt_load;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = ADDR_W'(fetch_pc_q + 1'b1);
    end
    if (redirect) begin
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_valid_d = ld_valid;
      if (ld_valid) begin
        ifid_instr_d = ld_instr;
        ifid_pc_d    = ld_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= ADDR_W'(RESET_PC);
      inflight_q   <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_load) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (redirect) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_skid #(
    .AW (ADDR_W),
    .DW (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (skid_flush),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .instr_i (imem.imem_rdata),
    .pc_i    (fetch_pc_q),
    .valid_o (skid_v),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_pc_q;

  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a
// synchronous memory returning instr k at addr k.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic [15:0] ifid_instr;
  logic [8:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic        halt_en = 1'b0;
  logic        inj = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifetch_if bus ();

  always @(posedge clk) begin
    bus.imem_rvalid <= bus.imem_req | inj;
    if (halt_en && bus.imem_addr == 9'd5)
      bus.imem_rdata <= 16'hE005;
    else
      bus.imem_rdata <= {7'd0, bus.imem_addr};
  end

  ifetch u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got=%0b exp=0", ifid_valid);
    end
    n_chk++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_halted got=%0b exp=0", halted);
    end
    n_chk++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req got=%0b exp=0", bus.imem_req);
    end
    n_chk++;
    if (ifid_instr !== 16'h0 || ifid_pc !== 9'h0) begin
      n_fail++;
      $display("FAIL rst_ifid got=%h/%h exp=0/0",
               ifid_instr, ifid_pc);
    end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) reset = 1'b0;
      #1;
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'(c)) begin
        n_fail++;
        $display("FAIL stream_req c=%0d got=%0b/%h exp=1/%h",
                 c, bus.imem_req, bus.imem_addr, 9'(c));
      end
      n_chk++;
      if (c >= 2) begin
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'(c - 2) ||
            ifid_pc !== 9'(c - 1)) begin
          n_fail++;
          $display("FAIL stream_ifid c=%0d got=%0b/%h/%h exp=1/%h/%h",
                   c, ifid_valid, ifid_instr, ifid_pc,
                   16'(c - 2), 9'(c - 1));
        end
      end else if (ifid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_bubble c=%0d got=%0b exp=0",
                 c, ifid_valid);
      end
    end
  endtask

  task automatic test_stall();
    int e_req [8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
    int e_addr [8]  = '{0, 0, 0, 0, 10, 11, 12, 13};
    int e_val [8]   = '{1, 1, 1, 1, 1, 0, 1, 1};
    int e_instr [8] = '{8, 8, 8, 8, 9, 0, 10, 11};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stall = (k < 3);
      #1;
      n_chk++;
      if (bus.imem_req !== 1'(e_req[k]) ||
          (e_req[k] == 1 && bus.imem_addr !== 9'(e_addr[k]))) begin
        n_fail++;
        $display("FAIL stall_req k=%0d got=%0b/%h exp=%0d/%h",
                 k, bus.imem_req, bus.imem_addr,
                 e_req[k], 9'(e_addr[k]));
      end
      n_chk++;
      if (ifid_valid !== 1'(e_val[k]) ||
          (e_val[k] == 1 &&
           (ifid_instr !== 16'(e_instr[k]) ||
            ifid_pc !== 9'(e_instr[k] + 1)))) begin
        n_fail++;
        $display("FAIL stall_ifid k=%0d got=%0b/%h/%h exp=%0d/%h/%h",
                 k, ifid_valid, ifid_instr, ifid_pc, e_val[k],
                 16'(e_instr[k]), 9'(e_instr[k] + 1));
      end
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 9'h040;
    #1;
    n_chk++;
    if (bus.imem_req !== 1'b0 || ifid_instr !== 16'd12) begin
      n_fail++;
      $display("FAIL redir_t0 got=%0b/%h exp=0/000c",
               bus.imem_req, ifid_instr);
    end
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    n_chk++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h040 ||
        ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_t1 got=%0b/%h/%0b exp=1/040/0",
               bus.imem_req, bus.imem_addr, ifid_valid);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.imem_addr !== 9'h041 || ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_t2 got=%h/%0b exp=041/0",
               bus.imem_addr, ifid_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 16'(9'h040 + k) ||
          ifid_pc !== 9'(9'h041 + k)) begin
        n_fail++;
        $display("FAIL redir_tgt k=%0d got=%0b/%h/%h exp=1/%h/%h",
                 k, ifid_valid, ifid_instr, ifid_pc,
                 16'(9'h040 + k), 9'(9'h041 + k));
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 9'h1FE;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_chk++;
    if (bus.imem_addr !== 9'h1FE || bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_a0 got=%0b/%h exp=1/1fe",
               bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.imem_addr !== 9'h1FF) begin
      n_fail++;
      $display("FAIL wrap_a1 got=%h exp=1ff", bus.imem_addr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.imem_addr !== 9'h000 || ifid_instr !== 16'h01FE ||
        ifid_pc !== 9'h1FF) begin
      n_fail++;
      $display("FAIL wrap_a2 got=%h/%h/%h exp=000/01fe/1ff",
               bus.imem_addr, ifid_instr, ifid_pc);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 16'h01FF ||
        ifid_pc !== 9'h000 || bus.imem_addr !== 9'h001) begin
      n_fail++;
      $display("FAIL wrap_pc got=%0b/%h/%h/%h exp=1/01ff/000/001",
               ifid_valid, ifid_instr, ifid_pc, bus.imem_addr);
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    halt_en = 1'b1;
    redirect = 1'b1;
    redirect_pc = 9'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      n_chk++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'(k + 1)) begin
        n_fail++;
        $display("FAIL halt_req k=%0d got=%0b/%h exp=1/%h",
                 k, bus.imem_req, bus.imem_addr, 9'(k + 1));
      end
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (halted !== 1'b1 || ifid_valid !== 1'b1 ||
        ifid_instr !== 16'hE005 || ifid_pc !== 9'd6 ||
        bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_load got=%0b/%0b/%h/%h/%0b exp=1/1/e005/006/0",
               halted, ifid_valid, ifid_instr, ifid_pc, bus.imem_req);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (halted !== 1'b1 || ifid_valid !== 1'b0 ||
          bus.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_idle k=%0d got=%0b/%0b/%0b exp=1/0/0",
                 k, halted, ifid_valid, bus.imem_req);
      end
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 9'd2;
    #1;
    n_chk++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_redir got=%0b/%0b exp=1/0",
               halted, bus.imem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    halt_en = 1'b0;
    #1;
    n_chk++;
    if (halted !== 1'b0 || bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 9'd2) begin
      n_fail++;
      $display("FAIL halt_resume got=%0b/%0b/%h exp=0/1/002",
               halted, bus.imem_req, bus.imem_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 16'd2) begin
      n_fail++;
      $display("FAIL halt_refetch got=%0b/%h exp=1/0002",
               ifid_valid, ifid_instr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset = 1'b1;
    inj = 1'b1;
    #1;
    n_chk++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_req got=%0b exp=0", bus.imem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    inj = 1'b0;
    #1;
    n_chk++;
    if (ifid_valid !== 1'b0 || halted !== 1'b0 ||
        bus.imem_req !== 1'b1 || bus.imem_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL rmid_first got=%0b/%0b/%0b/%h exp=0/0/1/000",
               ifid_valid, halted, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ifid_valid !== 1'b0 || bus.imem_addr !== 9'd1) begin
      n_fail++;
      $display("FAIL rmid_stale got=%0b/%h exp=0/001",
               ifid_valid, bus.imem_addr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 16'd0 ||
        ifid_pc !== 9'd1) begin
      n_fail++;
      $display("FAIL rmid_ifid got=%0b/%h/%h exp=1/0000/001",
               ifid_valid, ifid_instr, ifid_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
